// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on dout while non-empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                  (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the serializer.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic [7:0] tx_data,
  output logic       txd,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       tx_overflow
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned TW           = $clog2(CLKS_PER_BIT);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  localparam logic [TW-1:0] TIMER_MAX = TW'(CLKS_PER_BIT - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_bit,   w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_txd,   w_txd_nxt;
  logic          r_busy;
  logic          r_overflow;

  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic          w_tick;
  logic          w_drop;

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_en),
    .pop  (w_pop),
    .din  (tx_data),
    .dout (w_head),
    .full (w_full),
    .empty(w_empty)
  );

  assign w_tick = (r_timer == TIMER_MAX);
  assign w_drop = tx_en && w_full && !w_pop;

  // txd_nxt follows the current state, so the line lags the FSM by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer + 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_txd_nxt   = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_timer_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
        end
      end
      START: begin
        w_txd_nxt = 1'b0;
        if (w_tick) begin
          w_timer_nxt = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_txd_nxt = r_shift[0];
        if (w_tick) begin
          w_timer_nxt = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_timer_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
      r_busy     <= (r_state != IDLE) || !w_empty;
      r_overflow <= w_drop;
    end
  end

  assign txd         = r_txd;
  assign tx_busy     = r_busy;
  assign fifo_full   = w_full;
  assign tx_overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: queued bytes are checked against decoded line frames.
module tb_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       txd;
  logic       tx_busy;
  logic       fifo_full;
  logic       tx_overflow;

  uart_tx #(
    .CLK_HZ(400),
    .BAUD(100),
    .FIFO_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .txd        (txd),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_q[$];
  int unsigned starts[$];
  int          n_checks = 0;
  int          n_errors = 0;

  bit          mon_active = 0;
  bit          mon_has_exp = 0;
  logic [7:0]  mon_byte;
  int unsigned mon_t = 0;
  int unsigned busy_cnt = 0;
  int unsigned ovf_cnt = 0;
  bit          saw_full = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int unsigned t);
    int unsigned i;
    i = t / CPB;
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  // Line monitor: every cycle of a frame is compared with the queue head.
  always @(negedge clk) begin
    if (tx_busy === 1'b1) busy_cnt++;
    if (tx_overflow === 1'b1) ovf_cnt++;
    if (fifo_full === 1'b1) saw_full = 1;
    if (rst === 1'b1) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd === 1'b0) begin
        mon_active = 1;
        mon_t      = 0;
        starts.push_back(cyc);
        check("frame_expected", 32'(exp_q.size() != 0), 1);
        mon_has_exp = (exp_q.size() != 0);
        if (mon_has_exp) mon_byte = exp_q[0];
      end
    end else begin
      mon_t++;
    end
    if (mon_active && rst !== 1'b1) begin
      if (mon_has_exp) check("txd_bit", txd, frame_bit(mon_byte, mon_t));
      if (mon_t == 10*CPB - 1) begin
        mon_active = 0;
        if (mon_has_exp) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic en, input logic [7:0] d);
    tx_en   = en;
    tx_data = d;
    step();
  endtask

  task automatic wait_idle(input int unsigned budget, input bit scramble);
    int unsigned n;
    n = 0;
    while ((tx_busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < budget) begin
      if (scramble) tx_data = 8'($urandom);
      step();
      n++;
    end
    check("idle_timeout", 32'(n < budget), 1);
  endtask

  initial begin
    int unsigned t0;
    int unsigned ns;
    logic [7:0]  b2[4];
    logic [7:0]  v;

    rst = 1'b1; tx_en = 1'b0; tx_data = '0;
    repeat (3) step();
    check("rst_txd", txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", tx_overflow, 0);
    rst = 1'b0;
    step();

    // 1: single byte latency, frame and busy width
    busy_cnt = 0; ns = starts.size(); t0 = cyc;
    exp_q.push_back(8'hA5);
    drive(1'b1, 8'hA5);
    check("t1_busy_edgeN", tx_busy, 0);
    drive(1'b0, 8'h00);
    check("t1_busy_edgeN1", tx_busy, 1);
    wait_idle(200, 0);
    check("t1_nframes", starts.size() - ns, 1);
    if (starts.size() > ns) check("t1_fall", starts[ns], t0 + 3);
    check("t1_busy_cycles", busy_cnt, 41);

    // 2: back-to-back contiguous frames
    b2[0] = 8'h00; b2[1] = 8'hFF; b2[2] = 8'h55; b2[3] = 8'h81;
    saw_full = 0; ns = starts.size(); t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(b2[i]);
      drive(1'b1, b2[i]);
    end
    drive(1'b0, 8'h00);
    wait_idle(400, 0);
    check("t2_never_full", saw_full, 0);
    check("t2_nframes", starts.size() - ns, 4);
    if (starts.size() >= ns + 4)
      for (int i = 0; i < 4; i++) check("t2_start", starts[ns+i], t0 + 3 + 40*i);

    // 3: overflow drops the fifth queued write
    ovf_cnt = 0;
    exp_q.push_back(8'h11);
    drive(1'b1, 8'h11);
    drive(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      v = 8'(8'h22 + 8'h11 * i);
      exp_q.push_back(v);
      drive(1'b1, v);
      if (i == 2) check("t3_not_full", fifo_full, 0);
    end
    check("t3_full", fifo_full, 1);
    check("t3_ovf_pre", tx_overflow, 0);
    drive(1'b1, 8'h66);
    check("t3_ovf", tx_overflow, 1);
    check("t3_full_kept", fifo_full, 1);
    drive(1'b0, 8'h00);
    check("t3_ovf_pulse", tx_overflow, 0);
    wait_idle(400, 0);
    check("t3_ovf_cnt", ovf_cnt, 1);

    // 4: push while full, aligned with the pop at end of STOP
    ovf_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      v = 8'(8'hB0 + i);
      exp_q.push_back(v);
      drive(1'b1, v);
    end
    check("t4_full", fifo_full, 1);
    repeat (36) drive(1'b0, 8'h00);
    exp_q.push_back(8'hB5);
    drive(1'b1, 8'hB5);
    check("t4_ovf", tx_overflow, 0);
    check("t4_full_kept", fifo_full, 1);
    drive(1'b0, 8'h00);
    check("t4_ovf_next", tx_overflow, 0);
    wait_idle(600, 0);
    check("t4_ovf_cnt", ovf_cnt, 0);

    // 5: reset during DATA bit 3 with two bytes queued
    exp_q.push_back(8'hF7); drive(1'b1, 8'hF7);
    exp_q.push_back(8'hC2); drive(1'b1, 8'hC2);
    exp_q.push_back(8'hC3); drive(1'b1, 8'hC3);
    repeat (16) drive(1'b0, 8'h00);
    check("t5_pre_bit3", txd, 0);
    exp_q.delete();
    rst = 1'b1;
    step();
    check("t5_txd", txd, 1);
    check("t5_busy", tx_busy, 0);
    check("t5_full", fifo_full, 0);
    rst = 1'b0;
    ns = starts.size();
    repeat (60) step();
    check("t5_no_frame", starts.size() - ns, 0);
    check("t5_busy_after", tx_busy, 0);
    check("t5_txd_after", txd, 1);

    // 6: tx_data scrambled after the push
    ns = starts.size();
    exp_q.push_back(8'h3C);
    drive(1'b1, 8'h3C);
    tx_en = 1'b0;
    wait_idle(200, 1);
    check("t6_nframes", starts.size() - ns, 1);

    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
